// File: rtl/fft_cp_pkg.sv
// Shared definitions for the FFT cyclic-prefix remover: FSM state type,
// slot geometry and the sample-counter width helper.
package fft_cp_pkg;

  // Phase of the incoming OFDM symbol stream.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a start-of-frame marker
    ST_CP   = 2'd1,  // discarding cyclic-prefix samples
    ST_BODY = 2'd2   // forwarding FFT body samples
  } state_e;

  // Symbols per slot; the symbol index wraps after the last one.
  localparam int unsigned SLOT_LEN = 14;

  // Symbols of a slot that carry the long cyclic prefix.
  localparam int unsigned LONG_CP_SYM_A = 0;
  localparam int unsigned LONG_CP_SYM_B = 7;

  // One extra bit over log2(NFFT) so the counter can hold NFFT itself.
  function automatic int unsigned cnt_width(input int unsigned lgnfft);
    return lgnfft + 1;
  endfunction

endpackage

// File: rtl/fft_cp_remover.sv
// Strips the cyclic prefix from a stream of OFDM symbols and hands the
// NFFT body samples of each symbol to the FFT with a frame sync, the
// symbol index within the slot, and an abort flag for abandoned frames.
module fft_cp_remover
  import fft_cp_pkg::*;
#(
  parameter int IWIDTH      = 16,
  parameter int LGNFFT      = 8,
  parameter int CP_LEN      = 18,
  parameter int CP_LEN_LONG = 20
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [2*IWIDTH-1:0]   i_sample,
  input  logic                  i_sof,
  output logic                  o_ce,
  output logic [2*IWIDTH-1:0]   o_sample,
  output logic                  o_sync,
  output logic [3:0]            o_sym_idx,
  output logic                  o_abort
);

  localparam int unsigned CW = cnt_width(LGNFFT);
  localparam logic [CW-1:0] NFFT_LAST = CW'((1 << LGNFFT) - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            sym_q, sym_d;
  logic                  ce_q, ce_d;
  logic                  sync_q, sync_d;
  logic                  abort_q, abort_d;
  logic [3:0]            sym_out_q, sym_out_d;
  logic [2*IWIDTH-1:0]   sample_q, sample_d;

  logic                  long_cp;
  logic [CW-1:0]         cp_last;
  logic                  body_mid;
  logic                  body_last;
  logic [3:0]            sym_next;

  // CP length follows the symbol index; helper flags for the FSM.
  always_comb begin
    long_cp   = (sym_q == 4'(LONG_CP_SYM_A)) || (sym_q == 4'(LONG_CP_SYM_B));
    cp_last   = long_cp ? CW'(CP_LEN_LONG - 1) : CW'(CP_LEN - 1);
    // In BODY the counter never reaches NFFT, so a non-zero count means
    // some body samples have already gone to the FFT.
    body_mid  = (state_q == ST_BODY) && (cnt_q != '0);
    body_last = (state_q == ST_BODY) && (cnt_q == NFFT_LAST);
    sym_next  = (sym_q == 4'(SLOT_LEN - 1)) ? 4'd0 : sym_q + 4'd1;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned; a missing default would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sym_d     = sym_q;
    ce_d      = 1'b0;
    sync_d    = 1'b0;
    abort_d   = 1'b0;
    sym_out_d = sym_out_q;
    sample_d  = sample_q;

    if (!i_enable) begin
      // Disable wins over everything, including a coincident i_sof.
      state_d = ST_IDLE;
      cnt_d   = '0;
      abort_d = body_mid;
    end else if (i_valid && i_sof) begin
      state_d = ST_CP;
      sym_d   = 4'd0;
      if (body_last) begin
        // Marker on the final body sample: finish this frame cleanly and
        // start symbol 0 with the next sample as its first CP sample.
        ce_d      = 1'b1;
        sample_d  = i_sample;
        sym_out_d = sym_q;
        cnt_d     = '0;
      end else begin
        // The marker sample itself is CP sample 0 of symbol 0.
        abort_d = body_mid;
        cnt_d   = CW'(1);
      end
    end else if (i_valid) begin
      case (state_q)
        ST_CP: begin
          if (cnt_q == cp_last) begin
            state_d = ST_BODY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_BODY: begin
          ce_d      = 1'b1;
          sync_d    = (cnt_q == '0);
          sample_d  = i_sample;
          sym_out_d = sym_q;
          if (cnt_q == NFFT_LAST) begin
            state_d = ST_CP;
            cnt_d   = '0;
            sym_d   = sym_next;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sym_q     <= '0;
      ce_q      <= 1'b0;
      sync_q    <= 1'b0;
      abort_q   <= 1'b0;
      sym_out_q <= '0;
      sample_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_q     <= sym_d;
      ce_q      <= ce_d;
      sync_q    <= sync_d;
      abort_q   <= abort_d;
      sym_out_q <= sym_out_d;
      sample_q  <= sample_d;
    end
  end

  assign o_ce      = ce_q;
  assign o_sample  = sample_q;
  assign o_sync    = sync_q;
  assign o_sym_idx = sym_out_q;
  assign o_abort   = abort_q;

endmodule

// File: tb/tb_fft_cp_remover.sv
// Self-checking bench for fft_cp_remover: a symbol-position reference
// model checks every cycle, a vector table checks per-run totals, and
// hand-written sequences cover disable, ignored markers and reset.
module tb_fft_cp_remover;

  localparam int IW      = 16;
  localparam int NFFT    = 256;
  localparam int CP_S    = 18;
  localparam int CP_L    = 20;
  localparam int SLOT    = 14;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_enable;
  logic              i_valid;
  logic [2*IW-1:0]   i_sample;
  logic              i_sof;
  logic              o_ce;
  logic [2*IW-1:0]   o_sample;
  logic              o_sync;
  logic [3:0]        o_sym_idx;
  logic              o_abort;

  fft_cp_remover #(
    .IWIDTH(IW), .LGNFFT(8), .CP_LEN(CP_S), .CP_LEN_LONG(CP_L)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_valid(i_valid), .i_sample(i_sample), .i_sof(i_sof),
    .o_ce(o_ce), .o_sample(o_sample), .o_sync(o_sync),
    .o_sym_idx(o_sym_idx), .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference model: position within the current symbol (CP + body),
  // counted from the first CP sample.
  bit            m_active = 1'b0;
  int            m_sym    = 0;
  int            m_pos    = 0;
  bit            e_ce, e_sync, e_abort;
  int            e_sym;
  logic [2*IW-1:0] e_sample;

  function automatic int cp_of(input int s);
    return (s == 0 || s == 7) ? CP_L : CP_S;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_sym = 0; m_pos = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input bit sof,
                            input logic [2*IW-1:0] smp);
    int cp;
    cp = cp_of(m_sym);
    e_ce = 1'b0; e_sync = 1'b0; e_abort = 1'b0;
    if (!en) begin
      if (m_active && m_pos > cp) e_abort = 1'b1;
      m_active = 1'b0;
    end else if (v && sof) begin
      if (m_active && m_pos == cp + NFFT - 1) begin
        e_ce = 1'b1; e_sample = smp; e_sym = m_sym;
        m_pos = 0;
      end else begin
        if (m_active && m_pos > cp) e_abort = 1'b1;
        m_pos = 1;
      end
      m_active = 1'b1;
      m_sym    = 0;
    end else if (v && m_active) begin
      if (m_pos >= cp) begin
        e_ce = 1'b1; e_sync = (m_pos == cp); e_sample = smp; e_sym = m_sym;
      end
      m_pos++;
      if (m_pos == cp + NFFT) begin
        m_pos = 0;
        m_sym = (m_sym + 1) % SLOT;
      end
    end
  endtask

  int obs_ce = 0, obs_sync = 0, obs_abort = 0;

  // One clock: apply inputs, advance the model, compare 1 ns after the edge.
  task automatic drive(input bit en, input bit v, input bit sof,
                       input logic [2*IW-1:0] smp);
    bit ok;
    i_enable = en; i_valid = v; i_sof = sof; i_sample = smp;
    model_step(en, v, sof, smp);
    @(posedge i_clk);
    #1;
    obs_ce    += int'(o_ce);
    obs_sync  += int'(o_sync);
    obs_abort += int'(o_abort);
    ok = (o_ce === e_ce) && (o_sync === e_sync) && (o_abort === e_abort) &&
         (!e_ce || (o_sample === e_sample && int'(o_sym_idx) == e_sym));
    check(ok, "cycle", $sformatf(
      "got ce=%0b sync=%0b abort=%0b sym=%0d data=%h, want ce=%0b sync=%0b abort=%0b sym=%0d data=%h",
      o_ce, o_sync, o_abort, o_sym_idx, o_sample, e_ce, e_sync, e_abort, e_sym, e_sample));
  endtask

  function automatic logic [2*IW-1:0] ramp(input int k);
    return {IW'(k), IW'(k * 7 + 3)};
  endfunction

  task automatic clear_obs();
    obs_ce = 0; obs_sync = 0; obs_abort = 0;
  endtask

  // Vector: valid samples with i_sof on sample 0 and optionally on sof2_at,
  // then one disabled cycle; expected totals worked out by hand.
  typedef struct {
    string name;
    int    n_samples;
    int    sof2_at;
    int    valid_pct;
    int    exp_ce;
    int    exp_sync;
    int    exp_abort;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int k;
    bit take;
    clear_obs();
    k = 0;
    while (k < v.n_samples) begin
      take = (v.valid_pct >= 100) || (int'($urandom_range(99)) < v.valid_pct);
      if (take) begin
        drive(1'b1, 1'b1, (k == 0) || (k == v.sof2_at), ramp(k));
        k++;
      end else begin
        drive(1'b1, 1'b0, 1'($urandom_range(1)), 2*IW'($urandom));
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    check(obs_ce == v.exp_ce, {v.name, "_ce_count"},
          $sformatf("got %0d want %0d", obs_ce, v.exp_ce));
    check(obs_sync == v.exp_sync, {v.name, "_sync_count"},
          $sformatf("got %0d want %0d", obs_sync, v.exp_sync));
    check(obs_abort == v.exp_abort, {v.name, "_abort_count"},
          $sformatf("got %0d want %0d", obs_abort, v.exp_abort));
  endtask

  initial begin
    // One long-CP symbol from a marker: body carries samples 20..275.
    vecs[0] = '{"one_sym",     276,   -1, 100,  256,  1, 0};
    // Full slot (20+256)*2 + (18+256)*12 = 3840, then sym0 CP + 1 body.
    vecs[1] = '{"slot_wrap",   3861,  -1, 100, 3585, 15, 1};
    // Resync at body sample 100 of symbol 3 (sample 942), then one symbol.
    vecs[2] = '{"resync_sym3", 1218, 942, 100, 1124,  5, 1};
    // Marker on body sample 255 completes the frame, then sym0 again.
    vecs[3] = '{"sof_on_last", 552,  275, 100,  512,  2, 0};
    // 50 % valid density, one symbol.
    vecs[4] = '{"gappy_sym",   276,   -1,  50,  256,  1, 0};
    // Marker inside the CP: no abort, restart from there.
    vecs[5] = '{"sof_in_cp",   286,   10, 100,  256,  1, 0};
    // Marker when body count is still 0: no abort.
    vecs[6] = '{"sof_body0",   296,   20, 100,  256,  1, 0};

    i_reset_n = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
    i_sample = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check(o_ce == 0 && o_sync == 0 && o_abort == 0 && o_sym_idx == 0 && o_sample == 0,
          "reset_state", $sformatf("got ce=%0b sync=%0b abort=%0b sym=%0d data=%h, want all 0",
          o_ce, o_sync, o_abort, o_sym_idx, o_sample));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // i_sof with i_valid low is ignored: later samples stay unforwarded.
    clear_obs();
    repeat (3) drive(1'b1, 1'b0, 1'b1, ramp(1));
    for (int k = 0; k < 300; k++) drive(1'b1, 1'b1, 1'b0, ramp(k));
    check(obs_ce == 0, "sof_without_valid",
          $sformatf("got %0d ce pulses want 0", obs_ce));

    // Disable mid-body (with a marker while disabled), then clean restart.
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 70; k++) drive(1'b1, 1'b1, k == 0, ramp(k));
    clear_obs();
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, k == 2, ramp(500 + k));
    check(obs_abort == 1 && obs_ce == 0, "disable_mid_body",
          $sformatf("got abort=%0d ce=%0d want abort=1 ce=0", obs_abort, obs_ce));
    clear_obs();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, ramp(600 + k));
    for (int k = 0; k < 276; k++) drive(1'b1, 1'b1, k == 0, ramp(700 + k));
    check(obs_ce == 256 && obs_sync == 1 && obs_abort == 0, "reenable_restart",
          $sformatf("got ce=%0d sync=%0d abort=%0d want 256/1/0", obs_ce, obs_sync, obs_abort));

    // Asynchronous reset in the middle of a body.
    for (int k = 0; k < 80; k++) drive(1'b1, 1'b1, k == 0, ramp(1000 + k));
    check(o_ce == 1 && o_sample != 0, "pre_reset_active",
          $sformatf("got ce=%0b data=%h want ce=1 data!=0", o_ce, o_sample));
    #2;
    i_reset_n = 1'b0;
    #1;
    check(o_ce == 0 && o_sync == 0 && o_abort == 0 && o_sym_idx == 0 && o_sample == 0,
          "async_reset", $sformatf("got ce=%0b sync=%0b abort=%0b sym=%0d data=%h, want all 0",
          o_ce, o_sync, o_abort, o_sym_idx, o_sample));
    i_valid = 1'b0; i_sof = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
    clear_obs();
    for (int k = 0; k < 300; k++) drive(1'b1, 1'b1, 1'b0, ramp(2000 + k));
    check(obs_ce == 0, "no_ce_after_reset",
          $sformatf("got %0d ce pulses want 0", obs_ce));
    for (int k = 0; k < 276; k++) drive(1'b1, 1'b1, k == 0, ramp(3000 + k));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
